// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator: default bus widths, layer-engine
// requester IDs and the memory arbiter state encoding.
package cnn_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 10;

    localparam int REQ_CONV = 0;
    localparam int REQ_POOL = 1;
    localparam int REQ_FC1  = 2;
    localparam int REQ_FC2  = 3;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fmap_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
// The request vector is doubled so the wrap becomes a plain lowest-bit search.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] masked;
    logic           found;

    always_comb begin
        req_dbl = {req_i, req_i};
        masked  = req_dbl & ({(2*N){1'b1}} << ptr_i);
        idx_o   = '0;
        found   = 1'b0;
        for (int j = 0; j < 2*N; j++) begin
            if (!found && masked[j]) begin
                found = 1'b1;
                idx_o = IDX_W'(j % N);
            end
        end
        gnt_o = '0;
        if (found) gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/fmap_mem_arbiter.sv
// Single-port feature-map RAM shared by the layer engines, with round-robin
// arbitration, bounded burst locking and a registered read return.
module fmap_mem_arbiter
    import cnn_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = 784,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        lock_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      err_o,
    output logic                      busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   gnt_idx;
    logic               owner_hold;
    logic               others_pending;

    logic               acc_en;
    logic               acc_we;
    logic [ADDR_W-1:0]  acc_addr;
    logic [DATA_W-1:0]  acc_wdata;
    logic               in_range;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [NUM_REQ-1:0] rvalid_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    assign owner_hold     = (state_q == LOCKED) && req_i[owner_q];
    assign others_pending = |(req_i & ~(NUM_REQ'(1) << owner_q));
    assign cnt_inc        = (cnt_q == CNT_W'(MAX_BURST)) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (owner_hold) begin
            cnt_d = cnt_inc;
            // Owner gives up on its own, or is forced out once the burst cap is hit with others waiting.
            if (!lock_i[owner_q] || (cnt_inc == CNT_W'(MAX_BURST) && others_pending)) begin
                state_d = ARB;
                ptr_d   = wrap_inc(owner_q);
                cnt_d   = '0;
            end
        end else if (|req_i) begin
            ptr_d = wrap_inc(pick_idx);
            if (lock_i[pick_idx]) begin
                state_d = LOCKED;
                owner_d = pick_idx;
                cnt_d   = CNT_W'(1);
            end else begin
                state_d = ARB;
                cnt_d   = '0;
            end
        end else begin
            state_d = ARB;
            cnt_d   = '0;
        end
    end

    always_comb begin
        gnt_o   = pick_gnt;
        gnt_idx = pick_idx;
        if (owner_hold) begin
            gnt_o   = NUM_REQ'(1) << owner_q;
            gnt_idx = owner_q;
        end
    end

    assign acc_en    = |gnt_o;
    assign acc_we    = we_i[gnt_idx];
    assign acc_addr  = addr_i[gnt_idx*ADDR_W +: ADDR_W];
    assign acc_wdata = wdata_i[gnt_idx*DATA_W +: DATA_W];
    assign in_range  = 32'(acc_addr) < 32'(DEPTH);

    // RAM contents survive reset; only the access itself is blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && acc_en && acc_we && in_range) begin
            mem_q[acc_addr] <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= (acc_en && !acc_we) ? gnt_o : '0;
            if (acc_en && !acc_we) begin
                rdata_q <= in_range ? mem_q[acc_addr] : '0;
            end
            err_q <= acc_en && !in_range;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign busy_o   = (state_q == LOCKED);

endmodule

// File: tb/tb_fmap_mem_arbiter.sv
// Directed bench for fmap_mem_arbiter; read returns and error pulses are checked
// by a scoreboard monitor, grants and status directly after each drive.
module tb_fmap_mem_arbiter;

    typedef struct packed {
        logic [3:0] rv;
        logic [7:0] d;
        logic       e;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req, lock, we;
    logic [39:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt, rvalid;
    logic [7:0]  rdata;
    logic        err, busy;

    logic [9:0]  addr_a  [4];
    logic [7:0]  wdata_a [4];
    logic [9:0]  s_addr  [4];
    logic [7:0]  s_wdata [4];
    logic [7:0]  mdl [1024];
    exp_t        sbq [$];

    int n_checks = 0;
    int n_errors = 0;

    fmap_mem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .lock_i   (lock),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err),
        .busy_o   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < 4; i++) begin
            addr[i*10 +: 10] = addr_a[i];
            wdata[i*8 +: 8]  = wdata_a[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive after the edge, check the grant mid-cycle, record the expected return.
    task automatic step(input logic rst_v, input logic [3:0] r, input logic [3:0] l,
                        input logic [3:0] w, input logic [3:0] eg, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst  = rst_v;
        req  = r;
        lock = l;
        we   = w;
        for (int i = 0; i < 4; i++) begin
            addr_a[i]  = s_addr[i];
            wdata_a[i] = s_wdata[i];
        end
        @(negedge clk);
        chk(nm, 32'(gnt), 32'(eg));
        for (int i = 0; i < 4; i++) begin
            if (eg[i] && !rst_v) begin
                if (w[i]) begin
                    if (addr_a[i] < 10'd784) mdl[addr_a[i]] = wdata_a[i];
                    else begin
                        e.rv = 4'b0000; e.d = 8'h00; e.e = 1'b1;
                        sbq.push_back(e);
                    end
                end else begin
                    e.rv = 4'b0001 << i;
                    e.d  = (addr_a[i] < 10'd784) ? mdl[addr_a[i]] : 8'h00;
                    e.e  = (addr_a[i] >= 10'd784);
                    sbq.push_back(e);
                end
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rvalid !== 4'b0000 || err !== 1'b0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_return", {27'b0, rvalid, err}, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    chk("rvalid", 32'(rvalid), 32'(e.rv));
                    chk("err", 32'(err), 32'(e.e));
                    if (e.rv != 4'b0000) chk("rdata", 32'(rdata), 32'(e.d));
                end
            end
        end
    end

    logic [9:0] pre_a [10];
    logic [7:0] pre_d [10];

    initial begin
        rst = 1'b1; req = '0; lock = '0; we = '0;
        for (int i = 0; i < 4; i++) begin
            addr_a[i] = '0; wdata_a[i] = '0; s_addr[i] = '0; s_wdata[i] = '0;
        end
        pre_a = '{10'd100, 10'd101, 10'd102, 10'd103, 10'd104, 10'd105,
                  10'd783, 10'd16, 10'd288, 10'd200};
        pre_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                  8'h3C, 8'h61, 8'h62, 8'h77};

        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "rst_gnt");
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "rst_gnt");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "idle_gnt");
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Write then read back through requester 0.
        s_addr[0] = 10'd5; s_wdata[0] = 8'hA5;
        step(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, "t1_wr_gnt");
        step(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, "t1_rd_gnt");

        for (int k = 0; k < 10; k++) begin
            s_addr[0] = pre_a[k]; s_wdata[0] = pre_d[k];
            step(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, "preload_gnt");
        end

        // Rotation: pointer sits at 1 after the last grant to requester 0.
        for (int i = 0; i < 4; i++) s_addr[i] = 10'd5;
        for (int k = 0; k < 8; k++)
            step(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0001 << ((k + 1) % 4), "t2_rr_gnt");

        for (int k = 0; k < 6; k++) begin
            s_addr[2] = 10'(100 + k);
            step(1'b0, 4'b0101, (k < 5) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0100, "t3_burst_gnt");
        end
        step(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, "t3_after_gnt");

        // Burst cap: 16 locked grants, one to requester 3, then requester 1 again.
        s_addr[1] = 10'd5; s_addr[3] = 10'd5;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 4'b1010, 4'b0010, 4'b0000,
                 ((k % 17) == 16) ? 4'b1000 : 4'b0010, "t4_cap_gnt");
            if (k == 5) chk("t4_busy", 32'(busy), 32'h1);
        end
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "t4_idle_gnt");

        s_addr[0] = 10'd800;
        step(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, "t5_rd_oob_gnt");
        chk("t5_busy", 32'(busy), 32'h0);
        s_wdata[0] = 8'hFF;
        step(1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, "t5_wr_oob_gnt");
        s_addr[0] = 10'd783;
        step(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, "t5_rb_gnt");
        s_addr[0] = 10'd16;
        step(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, "t5_rb_gnt");
        s_addr[0] = 10'd288;
        step(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, "t5_rb_gnt");

        // Reset lands on the third cycle of a locked burst.
        s_addr[1] = 10'd5;
        step(1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, "t6_burst_gnt");
        step(1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, "t6_burst_gnt");
        step(1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, "t6_rst_gnt");
        s_addr[0] = 10'd200;
        step(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, "t6_post_rst_gnt");
        chk("t6_rvalid", 32'(rvalid), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "t6_idle_gnt");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "t6_idle_gnt");

        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
